uart_getch: RTL and testbench

Receive-side console block: the input counterpart of the `putch` output path. It polls the simulator UART input channel (`io_uart_in_valid` / `io_uart_in_ch`) on a fixed interval and buffers received characters in a small FIFO. The core drains the FIFO with a one-cycle read handshake. The block sits beside `putch` under `SimTop`, and the decode of the special "getch" instruction drives its read port.

---
 rtl/uart_getch.sv | 176 +++++++++++++++++
 tb/tb_uart_getch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_getch.sv
// Receive-side console block: polls the simulator UART input on a fixed interval
// and buffers received characters in a small FIFO drained by a one-cycle read handshake.
module uart_getch #(
    parameter int DEPTH         = 4,
    parameter int POLL_INTERVAL = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ren,
    output logic [7:0]               rdata,
    output logic                     rvalid,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     uart_in_valid,
    input  logic [7:0]               uart_in_ch
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [TW-1:0] TMR_RELOAD = TW'(POLL_INTERVAL - 1);
    localparam logic [7:0]    NO_CHAR    = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [TW-1:0]   tmr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [7:0]      mem_r [DEPTH];
    logic [7:0]      rdata_r;
    logic            rvalid_r;
    logic            overflow_r;

    logic            req_s;
    logic            empty_s;
    logic            full_s;
    logic            pop_s;
    logic            reply_ok_s;
    logic            push_s;
    logic            drop_s;

    assign empty_s    = (count_r == {CW{1'b0}});
    assign full_s     = (count_r == CW'(DEPTH));
    assign pop_s      = ren && !empty_s;
    assign reply_ok_s = req_s && (uart_in_ch != NO_CHAR);
    // A coincident pop frees the slot, so a push at full is legal then.
    assign push_s     = reply_ok_s && (!full_s || pop_s);
    assign drop_s     = reply_ok_s && full_s && !pop_s;

    // Poll FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Poll FSM next-state decision.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tmr_r == {TW{1'b0}}) begin
                    if (full_s) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!full_s || pop_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_REQ:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Poll FSM output decode.
    always_comb begin
        req_s = 1'b0;
        case (state_r)
            ST_REQ:  req_s = 1'b1;
            default: req_s = 1'b0;
        endcase
    end

    // Poll interval down-counter; frozen while parked in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_r <= TMR_RELOAD;
        end else if (req_s) begin
            tmr_r <= TMR_RELOAD;
        end else if ((state_r == ST_IDLE) && (tmr_r != {TW{1'b0}})) begin
            tmr_r <= tmr_r - TW'(1);
        end else begin
            tmr_r <= tmr_r;
        end
    end

    // FIFO storage; contents survive reset but are unreachable afterwards.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= uart_in_ch;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Read response register: head entry on a pop, NO_CHAR when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r  <= 8'h00;
            rvalid_r <= 1'b0;
        end else if (ren) begin
            rdata_r  <= empty_s ? NO_CHAR : mem_r[rd_ptr_r];
            rvalid_r <= 1'b1;
        end else begin
            rdata_r  <= rdata_r;
            rvalid_r <= 1'b0;
        end
    end

    // Sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign rdata         = rdata_r;
    assign rvalid        = rvalid_r;
    assign empty         = empty_s;
    assign count         = count_r;
    assign overflow      = overflow_r;
    assign uart_in_valid = req_s;

endmodule

// File: tb/tb_uart_getch.sv
// Directed self-checking bench for uart_getch (DEPTH=4, POLL_INTERVAL=16).
module tb_uart_getch;

    logic       clk;
    logic       rst;
    logic       ren;
    logic [7:0] rdata;
    logic       rvalid;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       uart_in_valid;
    logic [7:0] uart_in_ch;

    int n_checks;
    int n_fails;

    uart_getch #(.DEPTH(4), .POLL_INTERVAL(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .ren           (ren),
        .rdata         (rdata),
        .rvalid        (rvalid),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .uart_in_valid (uart_in_valid),
        .uart_in_ch    (uart_in_ch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 (first cycle after reset release).
    task automatic do_reset();
        rst        = 1'b1;
        ren        = 1'b0;
        uart_in_ch = 8'hFF;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_req();
        int k;
        k = 0;
        while (uart_in_valid !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        if (uart_in_valid !== 1'b1) begin
            check("wait_req_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic poll_reply(input logic [7:0] ch);
        wait_req();
        uart_in_ch = ch;
        step();
        uart_in_ch = 8'hFF;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"},    32'(count),         32'd0);
        check({tag, "_empty"},    32'(empty),         32'd1);
        check({tag, "_rdata"},    32'(rdata),         32'h00);
        check({tag, "_rvalid"},   32'(rvalid),        32'd0);
        check({tag, "_overflow"}, 32'(overflow),      32'd0);
        check({tag, "_valid"},    32'(uart_in_valid), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        ren = 1'b0;
        uart_in_ch = 8'hFF;

        // Poll schedule with no input available.
        do_reset();
        check_reset_outputs("reset");
        for (int c = 0; c < 56; c++) begin
            check($sformatf("poll_c%0d", c), 32'(uart_in_valid),
                  (c == 16 || c == 33 || c == 50) ? 32'd1 : 32'd0);
            check("idle_count",  32'(count),  32'd0);
            check("idle_rvalid", 32'(rvalid), 32'd0);
            step();
        end

        // Single character then a read.
        do_reset();
        for (int c = 0; c < 16; c++) step();
        check("first_req", 32'(uart_in_valid), 32'd1);
        uart_in_ch = 8'h41;
        step();
        uart_in_ch = 8'hFF;
        check("push_count", 32'(count), 32'd1);
        check("push_empty", 32'(empty), 32'd0);
        ren = 1'b1;
        step();
        ren = 1'b0;
        check("pop_count",  32'(count),  32'd0);
        check("pop_rvalid", 32'(rvalid), 32'd1);
        check("pop_rdata",  32'(rdata),  32'h41);
        step();
        check("hold_rvalid", 32'(rvalid), 32'd0);
        check("hold_rdata",  32'(rdata),  32'h41);

        // Read from an empty FIFO.
        ren = 1'b1;
        step();
        ren = 1'b0;
        check("empty_rvalid", 32'(rvalid), 32'd1);
        check("empty_rdata",  32'(rdata),  32'hFF);
        check("empty_count",  32'(count),  32'd0);

        // Fill to full, park in WAIT, release with one read, drain with wrap.
        do_reset();
        poll_reply(8'h30);
        poll_reply(8'h31);
        poll_reply(8'h32);
        poll_reply(8'h33);
        check("full_count", 32'(count), 32'd4);
        for (int c = 0; c < 40; c++) begin
            check("park_valid", 32'(uart_in_valid), 32'd0);
            step();
        end
        check("park_count", 32'(count), 32'd4);
        ren = 1'b1;
        step();
        ren = 1'b0;
        check("unpark_rdata", 32'(rdata),         32'h30);
        check("unpark_count", 32'(count),         32'd3);
        check("unpark_req",   32'(uart_in_valid), 32'd1);
        step();
        check("noreply_count", 32'(count), 32'd3);
        ren = 1'b1;
        step();
        check("drain_31", 32'(rdata), 32'h31);
        step();
        check("drain_32", 32'(rdata), 32'h32);
        step();
        check("drain_33", 32'(rdata), 32'h33);
        ren = 1'b0;
        check("drain_empty", 32'(empty), 32'd1);

        // Pop coincident with a push: count unchanged, order kept.
        poll_reply(8'h61);
        poll_reply(8'h62);
        check("pre_pp_count", 32'(count), 32'd2);
        wait_req();
        uart_in_ch = 8'h5A;
        ren = 1'b1;
        step();
        uart_in_ch = 8'hFF;
        check("pp_count",    32'(count),    32'd2);
        check("pp_rdata",    32'(rdata),    32'h61);
        check("pp_overflow", 32'(overflow), 32'd0);
        step();
        check("pp_next", 32'(rdata), 32'h62);
        step();
        ren = 1'b0;
        check("pp_tail", 32'(rdata), 32'h5A);
        check("pp_drained", 32'(count), 32'd0);

        // Reset in the middle of a REQ cycle.
        poll_reply(8'h70);
        check("pre_rst_count", 32'(count), 32'd1);
        wait_req();
        uart_in_ch = 8'h42;
        rst = 1'b1;
        step();
        rst = 1'b0;
        uart_in_ch = 8'hFF;
        check_reset_outputs("midreq_rst");
        for (int c = 0; c < 16; c++) begin
            check("post_rst_idle", 32'(uart_in_valid), 32'd0);
            step();
        end
        check("post_rst_req", 32'(uart_in_valid), 32'd1);
        check("post_rst_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
